// File: rtl/branch_target_buffer.sv
// Branch target buffer with per-entry saturating direction counters, read combinationally beside IF.
// Optional feature: define BTB_TAG_EN to store and compare tags; otherwise lookup is index-only.
module branch_target_buffer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned CTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam logic [CTR_W-1:0] WNT = CTR_W'((2 ** (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] WT  = CTR_W'(2 ** (CTR_W - 1));
   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_d [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_d [ENTRIES];

   logic [IDX_W-1:0]   lk_idx, upd_idx;
   logic               lk_tag_ok, upd_tag_ok, upd_hit;
   logic               unused_pc_bits;

   assign lk_idx  = lk_pc[IDX_W:1];
   assign upd_idx = upd_pc[IDX_W:1];

`ifdef BTB_TAG_EN
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 1;
   logic [TAG_W-1:0] tag_q [ENTRIES];
   logic [TAG_W-1:0] tag_d [ENTRIES];

   assign lk_tag_ok      = (tag_q[lk_idx] == lk_pc[ADDR_W-1:IDX_W+1]);
   assign upd_tag_ok     = (tag_q[upd_idx] == upd_pc[ADDR_W-1:IDX_W+1]);
   assign unused_pc_bits = lk_pc[0] ^ upd_pc[0];
`else
   // Index-only: any valid occupant of the index counts as a hit.
   assign lk_tag_ok      = 1'b1;
   assign upd_tag_ok     = 1'b1;
   assign unused_pc_bits = ^{lk_pc[ADDR_W-1:IDX_W+1], lk_pc[0],
                             upd_pc[ADDR_W-1:IDX_W+1], upd_pc[0]};
`endif

   assign upd_hit   = valid_q[upd_idx] & upd_tag_ok;
   assign lk_hit    = valid_q[lk_idx] & lk_tag_ok;
   assign lk_taken  = lk_hit & ctr_q[lk_idx][CTR_W-1];
   assign lk_target = tgt_q[lk_idx];

   always_comb begin
      valid_d = valid_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
`ifdef BTB_TAG_EN
      tag_d   = tag_q;
`endif
      // Flush wins over a coincident update; only valid bits are cleared.
      if (flush) begin
         valid_d = '0;
      end else if (upd_en) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
               tgt_d[upd_idx] = upd_target;
            end else if (ctr_q[upd_idx] != '0) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
            end
         end else if (upd_taken) begin
            valid_d[upd_idx] = 1'b1;
            tgt_d[upd_idx]   = upd_target;
            ctr_d[upd_idx]   = WT;
`ifdef BTB_TAG_EN
            tag_d[upd_idx]   = upd_pc[ADDR_W-1:IDX_W+1];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
`ifdef BTB_TAG_EN
            tag_q[i] <= '0;
`endif
         end
      end else begin
         valid_q <= valid_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
`ifdef BTB_TAG_EN
         tag_q   <= tag_d;
`endif
      end
   end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch target buffer with per-entry saturating direction counters for the RISC16 pipeline family. It sits beside the IF stage. It predicts, in the same cycle, whether the instruction at the fetch PC is a taken branch or jump, and supplies its target. The execute/writeback stage updates it with resolved outcomes. It generalises the fixed 1024-entry, 2-bit predictor buffer to configurable depth, address width and counter width, and adds allocation policy, flush, and optional tag matching.

## Interface
- `ADDR_W`, default 16: PC and target width.
- `IDX_W`, default 6: index bits. The buffer has 2^IDX_W entries.
- `CTR_W`, default 2: direction counter width. Must be ≥ 1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: invalidate all entries at the next edge.
- `lk_pc` in ADDR_W: fetch PC to look up.
- `lk_hit` out 1: a valid entry matches `lk_pc`.
- `lk_taken` out 1: predicted taken. Equals `lk_hit` AND counter MSB.
- `lk_target` out ADDR_W: stored target of the indexed entry.
- `upd_en` in 1: resolved branch/jump update strobe.
- `upd_pc` in ADDR_W: PC of the resolved instruction.
- `upd_taken` in 1: actual outcome.
- `upd_target` in ADDR_W: actual target. Meaningful when `upd_taken` is high.

## Operation
- Addresses are halfword aligned. Bit 0 is ignored.
- Index = pc[IDX_W:1].
- Tag = pc[ADDR_W-1:IDX_W+1].
- Each entry holds: valid, tag, target, and a CTR_W-bit counter.
- Weak-not-taken value WNT = 2^(CTR_W-1)-1. Weak-taken value WT = 2^(CTR_W-1).
- **Lookup** is combinational from entry storage. Hit = valid AND tag match. Tag match depends on the configuration (see Configuration).
- **Update**, applied when `upd_en` is high. Hit is evaluated against `upd_pc`.
  - Hit and taken: counter saturating-increments (max 2^CTR_W-1). Target is overwritten with `upd_target`.
  - Hit and not-taken: counter saturating-decrements (min 0). Target is unchanged. The entry stays valid.
  - Miss and taken: allocate, replacing any occupant. Set valid=1, tag, target, counter=WT.
  - Miss and not-taken: no state change.
- **Flush**: clears every valid bit. Targets, tags and counters are retained.
- **Priority**: `rst` > `flush` > `upd_en`. An update coincident with a flush is dropped.
- **Reset**: all valid bits are 0, targets and tags are 0, and all counters are WNT.
- Outputs after reset: `lk_hit`=0, `lk_taken`=0, `lk_target`=0.
- When `CTR_W`=1, WNT=0 and WT=1. Prediction is then last-outcome.

## Timing
- Lookup latency is 0 cycles, combinational from `lk_pc` and state.
- An update or flush sampled at edge N is visible to lookups from edge N onward. There is no write-to-read bypass.
- If a lookup and an update target the same index in the same cycle, the lookup returns the pre-update contents.
- Asserting `rst` mid-operation discards any coincident update. State is at reset values after that edge.
- Update inputs are ignored while `upd_en` is low.
- One update per cycle. Back-to-back updates to the same entry accumulate: each sees the state written by the previous one.

## Configuration
- `BTB_TAG_EN` defined:
  - Tag storage is instantiated.
  - Hit requires valid AND stored tag == pc tag.
  - An allocation on an aliased index replaces the occupant.
- `BTB_TAG_EN` undefined:
  - No tag storage.
  - Hit = valid only (index-only, aliasing permitted).
  - Hit-path updates apply to whatever entry shares the index.
  - Miss-and-taken applies only to invalid entries.

## Test plan
All scenarios use ADDR_W=16, IDX_W=4, CTR_W=2.

1. **Reset.** Lookup 0x0010 -> `lk_hit`=0, `lk_taken`=0, `lk_target`=0x0000.
2. **Allocation.** Update pc=0x0010, taken, target 0x0040. Next cycle, lookup 0x0010 -> hit=1, taken=1, target=0x0040 (counter=2).
3. **Counter saturation.** Starting from (2), apply not-taken three times, then taken twice, all at 0x0010. Expect counters 1, 0, 0, then 1, 2. `lk_taken` reads 0, 0, 0, 0, 1. hit=1 throughout.
4. **Aliasing.** 0x0030 shares index 8 with 0x0010.
   - With `BTB_TAG_EN`: lookup 0x0030 -> hit=0. Then update 0x0030 taken to 0x0100. Now 0x0030 hits with target 0x0100, and 0x0010 -> hit=0.
   - Without `BTB_TAG_EN`: lookup 0x0030 -> hit=1, target=0x0040.
5. **Flush with coincident update.** Assert `flush` and an update of 0x0020 taken in the same cycle. Next cycle, lookups of 0x0010 and 0x0020 -> hit=0.
6. **No allocation on not-taken miss; same-cycle read.**
   - Update 0x0050 not-taken on an empty entry -> 0x0050 never hits.
   - Lookup 0x0010 while updating 0x0010 taken to 0x0080 -> that cycle shows the old target. The next cycle shows 0x0080.
   - Assert `rst` with `upd_en` -> all lookups miss afterward.
